// File: rtl/linear_save_adder_pkg.sv
// -----------------------------------------------------------------------------
// linear_save_adder_pkg
//   Shared constants and bit-level helpers for the linear (ripple) save adder.
//   DEFAULT_WIDTH : default operand/sum width in bits
//   maj()         : 3-input majority, the carry function of a full-adder cell
// -----------------------------------------------------------------------------
package linear_save_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Carry out of a full adder: at least two of the three inputs are high.
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : linear_save_adder_pkg

// File: rtl/linear_save_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full-adder cell, the building block of the ripple carry chain.
//   a, b  : operand bits
//   cin   : carry from the next-lower bit
//   s     : sum bit
//   cout  : carry to the next-higher bit
// -----------------------------------------------------------------------------
module full_adder
    import linear_save_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj(a, b, cin);

endmodule : full_adder

// File: rtl/linear_save_adder.sv
// -----------------------------------------------------------------------------
// linear_save_adder
//   Registered WIDTH-bit unsigned adder built as a linear chain of full-adder
//   cells. {c_out, sum} = a + b + c_in, captured one clock after the operands
//   are sampled. One operation per cycle, no handshake.
//   clk   : system clock, rising-edge active
//   rst   : synchronous reset, active-high; clears sum and c_out
//   a, b  : WIDTH-bit unsigned operands
//   c_in  : carry into bit 0
//   sum   : registered low WIDTH bits of the result
//   c_out : registered carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module linear_save_adder
    import linear_save_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // NOTE: reset is tested first so it overrides the data update in the same
    // cycle; non-blocking assignments keep every register sampling pre-edge
    // values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            sum   <= sum_comb;
            c_out <= carry[WIDTH];
        end
    end

endmodule : linear_save_adder

// File: tb/tb_linear_save_adder.sv
// -----------------------------------------------------------------------------
// tb_linear_save_adder
//   Directed-vector bench for linear_save_adder (WIDTH = 8) plus a random
//   sweep checked against a 9-bit arithmetic reference.
// -----------------------------------------------------------------------------
module tb_linear_save_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    linear_save_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got {c_out,sum}=%03h expected %03h", tag, got, exp);
        end
    endtask

    // Drive operands on the falling edge, let the rising edge capture them,
    // then sample 1 time unit after that edge.
    task automatic step(input logic r, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc);
        @(negedge clk);
        rst  = r;
        a    = va;
        b    = vb;
        c_in = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vc, input logic [W:0] exp);
        step(1'b0, va, vb, vc);
        check(tag, {c_out, sum}, exp);
    endtask

    initial begin
        logic [W:0] exp;
        rst  = 1'b1;
        a    = 8'hFF;
        b    = 8'hFF;
        c_in = 1'b1;

        // Reset held for two cycles with all-ones operands on the inputs.
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        check("reset_cycle0", {c_out, sum}, 9'h000);
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        check("reset_cycle1", {c_out, sum}, 9'h000);

        op("basic_2A_B5",   8'h2A, 8'hB5, 1'b0, 9'h0DF);
        op("max_FF_FF_1",   8'hFF, 8'hFF, 1'b1, 9'h1FF);
        op("wrap_FF_00_1",  8'hFF, 8'h00, 1'b1, 9'h100);
        op("wrap_80_80_0",  8'h80, 8'h80, 1'b0, 9'h100);
        op("zero_00_00_0",  8'h00, 8'h00, 1'b0, 9'h000);

        // Back-to-back: each result appears exactly one edge after its inputs.
        op("b2b_01_01_0",   8'h01, 8'h01, 1'b0, 9'h002);
        // Before the next edge the previous result must still be held.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; c_in = 1'b0;
        #1;
        check("hold_before_edge", {c_out, sum}, 9'h002);
        @(posedge clk);
        #1;
        check("b2b_0F_01_0", {c_out, sum}, 9'h010);
        op("b2b_7F_01_1",   8'h7F, 8'h01, 1'b1, 9'h081);

        // Reset mid-stream discards the operation presented in that cycle.
        step(1'b1, 8'h55, 8'h22, 1'b1);
        check("midstream_reset", {c_out, sum}, 9'h000);
        op("resume_10_20_0", 8'h10, 8'h20, 1'b0, 9'h030);
        op("resume_C3_5A_1", 8'hC3, 8'h5A, 1'b1, 9'h11E);

        // Random sweep against the full-width arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra  = W'($urandom_range(0, 255));
            rb  = W'($urandom_range(0, 255));
            rc  = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            op("random", ra, rb, rc, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_linear_save_adder
